// File: rtl/phase_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the phase_arbiter traffic/pedestrian phase controller:
//   - phase_state_e : FSM state encoding (IDLE, GREEN, YELLOW, ALLRED)
//   - ROAD1/ROAD2/PED1/PED2 : requester bit positions in req/grant/yellow
//   - DEF_* : default timing constants used as parameter defaults
//   - bcd_of / bcd_dec : helpers for the packed-BCD remain display
//     (used when PHASE_BCD_EN is defined)
// -----------------------------------------------------------------------------
package phase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } phase_state_e;

    localparam int NUM_REQ = 4;
    localparam int ROAD1   = 0;
    localparam int ROAD2   = 1;
    localparam int PED1    = 2;
    localparam int PED2    = 3;

    localparam int DEF_TICK_DIV = 50000000;
    localparam int DEF_GREEN_S  = 10;
    localparam int DEF_YELLOW_S = 2;
    localparam int DEF_ALLRED_S = 1;

    // Two packed BCD digits, tens in [7:4]; valid for 0..99.
    function automatic logic [7:0] bcd_of(input int n);
        bcd_of = {4'(n / 10), 4'(n % 10)};
    endfunction

    // BCD decrement by one; a zero units digit borrows from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            bcd_dec = {v[7:4] - 4'd1, 4'd9};
        end else begin
            bcd_dec = {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

endpackage

// File: rtl/sec_tick.sv
// -----------------------------------------------------------------------------
// sec_tick
// Divide-by-TICK_DIV prescaler producing a one-cycle pulse per second.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset (count -> 0)
//   restart  in   clears the count so a new phase gets a full first second
//   tick     out  high for the one cycle in which count == TICK_DIV-1
// -----------------------------------------------------------------------------
module sec_tick #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_arbiter.sv
// -----------------------------------------------------------------------------
// phase_arbiter
// Round-robin phase controller for two road approaches and two pedestrian
// crossings. Each served requester gets GREEN, then (roads only) YELLOW, then
// an ALLRED clearance; the next winner is chosen when ALLRED expires.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   req      in   [3:0] level requests: [0] road1 [1] road2 [2] ped1 [3] ped2
//   grant    out  [3:0] one-hot green, zero outside GREEN
//   yellow   out  [3:0] one-hot yellow, bits [3:2] always zero
//   all_red  out  high in IDLE and ALLRED
//   remain   out  [7:0] seconds left in current phase, 0 in IDLE
//   busy     out  high whenever the controller is not IDLE
//
// Configuration macro: PHASE_BCD_EN -- when defined, remain counts in two
// packed BCD digits; otherwise it is plain binary.
//
// Timing: every output is a registered image of the FSM state of the previous
// cycle, so a request sampled at edge n latches into pend at n, starts GREEN
// at n+1 and shows on grant after n+2.
// -----------------------------------------------------------------------------
module phase_arbiter
    import phase_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int GREEN_S  = DEF_GREEN_S,
    parameter int YELLOW_S = DEF_YELLOW_S,
    parameter int ALLRED_S = DEF_ALLRED_S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [7:0] remain,
    output logic       busy
);

`ifdef PHASE_BCD_EN
    localparam logic [7:0] GREEN_LD  = bcd_of(GREEN_S);
    localparam logic [7:0] YELLOW_LD = bcd_of(YELLOW_S);
    localparam logic [7:0] ALLRED_LD = bcd_of(ALLRED_S);

    function automatic logic [7:0] rem_dec(input logic [7:0] v);
        rem_dec = bcd_dec(v);
    endfunction
`else
    localparam logic [7:0] GREEN_LD  = 8'(GREEN_S);
    localparam logic [7:0] YELLOW_LD = 8'(YELLOW_S);
    localparam logic [7:0] ALLRED_LD = 8'(ALLRED_S);

    function automatic logic [7:0] rem_dec(input logic [7:0] v);
        rem_dec = v - 8'd1;
    endfunction
`endif

    phase_state_e state_q, state_d;
    logic [1:0]   cur_q, cur_d;     // requester owning the current phase
    logic [1:0]   last_q, last_d;   // most recently granted requester
    logic [3:0]   pend_q, pend_d;
    logic [7:0]   rem_q, rem_d;

    logic [3:0]   grant_q, grant_d;
    logic [3:0]   yellow_q, yellow_d;
    logic         all_red_q, all_red_d;
    logic [7:0]   remain_q, remain_d;
    logic         busy_q, busy_d;

    logic         tick;
    logic         restart;
    logic         win_valid;
    logic [1:0]   win_idx;
    logic [3:0]   clr_mask;
    logic         cur_is_road;

    sec_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Round-robin search starting one past the last grant; the 2-bit index
    // wraps naturally, and the final step revisits last_q itself.
    always_comb begin
        logic [1:0] idx;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_q + 2'(i);
            if (!win_valid && pend_q[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign cur_is_road = (cur_q == 2'(ROAD1)) || (cur_q == 2'(ROAD2));

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        rem_d    = rem_q;
        clr_mask = 4'b0000;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d           = ST_GREEN;
                    cur_d             = win_idx;
                    last_d            = win_idx;
                    rem_d             = GREEN_LD;
                    clr_mask[win_idx] = 1'b1;
                end
            end
            ST_GREEN: begin
                if (tick) begin
                    if (rem_q == 8'd1) begin
                        if (cur_is_road) begin
                            state_d = ST_YELLOW;
                            rem_d   = YELLOW_LD;
                        end else begin
                            state_d = ST_ALLRED;
                            rem_d   = ALLRED_LD;
                        end
                    end else begin
                        rem_d = rem_dec(rem_q);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (rem_q == 8'd1) begin
                        state_d = ST_ALLRED;
                        rem_d   = ALLRED_LD;
                    end else begin
                        rem_d = rem_dec(rem_q);
                    end
                end
            end
            ST_ALLRED: begin
                if (tick) begin
                    if (rem_q == 8'd1) begin
                        if (win_valid) begin
                            state_d           = ST_GREEN;
                            cur_d             = win_idx;
                            last_d            = win_idx;
                            rem_d             = GREEN_LD;
                            clr_mask[win_idx] = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            rem_d   = 8'd0;
                        end
                    end else begin
                        rem_d = rem_dec(rem_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = 8'd0;
            end
        endcase

        // A request present in its own grant cycle re-arms its pending bit.
        pend_d  = (pend_q & ~clr_mask) | req;
        restart = (state_d != state_q);

        grant_d   = (state_q == ST_GREEN)  ? (4'b0001 << cur_q) : 4'b0000;
        yellow_d  = (state_q == ST_YELLOW) ? (4'b0001 << cur_q) : 4'b0000;
        all_red_d = (state_q == ST_IDLE) || (state_q == ST_ALLRED);
        remain_d  = rem_q;
        busy_d    = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_q     <= 2'd0;
            last_q    <= 2'd3;
            pend_q    <= 4'b0000;
            rem_q     <= 8'd0;
            grant_q   <= 4'b0000;
            yellow_q  <= 4'b0000;
            all_red_q <= 1'b1;
            remain_q  <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            rem_q     <= rem_d;
            grant_q   <= grant_d;
            yellow_q  <= yellow_d;
            all_red_q <= all_red_d;
            remain_q  <= remain_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign yellow  = yellow_q;
    assign all_red = all_red_q;
    assign remain  = remain_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_phase_arbiter.sv
// -----------------------------------------------------------------------------
// tb_phase_arbiter
// Directed bench for phase_arbiter (TICK_DIV=4, GREEN_S=3, YELLOW_S=2,
// ALLRED_S=1) plus a second instance with GREEN_S=12 for the remain encoding.
// A phase-schedule model predicts outputs every cycle; directed tests add
// hand-computed literal checks. PHASE_BCD_EN selects the remain encoding.
// -----------------------------------------------------------------------------
module tb_phase_arbiter;

    localparam int TD = 4;
    localparam int GS = 3;
    localparam int YS = 2;
    localparam int AS = 1;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] req2  = 4'b0000;

    logic [3:0] grant, yellow;
    logic       all_red, busy;
    logic [7:0] remain;
    logic [3:0] grant2, yellow2;
    logic       all_red2, busy2;
    logic [7:0] remain2;

    always #5 clk = ~clk;

    phase_arbiter #(
        .TICK_DIV (TD), .GREEN_S (GS), .YELLOW_S (YS), .ALLRED_S (AS)
    ) u_dut (
        .clk (clk), .reset (reset), .req (req),
        .grant (grant), .yellow (yellow), .all_red (all_red),
        .remain (remain), .busy (busy)
    );

    phase_arbiter #(
        .TICK_DIV (TD), .GREEN_S (12), .YELLOW_S (YS), .ALLRED_S (AS)
    ) u_dut12 (
        .clk (clk), .reset (reset), .req (req2),
        .grant (grant2), .yellow (yellow2), .all_red (all_red2),
        .remain (remain2), .busy (busy2)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic       ar;
        logic [7:0] rem;
        logic       busy;
    } out_t;

    function automatic logic [7:0] enc(input int n);
`ifdef PHASE_BCD_EN
        enc = 8'((n / 10) * 16 + (n % 10));
`else
        enc = 8'(n);
`endif
    endfunction

    function automatic out_t mk(input logic [3:0] g, input logic [3:0] y,
                                input logic ar, input logic [7:0] rem, input logic b);
        out_t o;
        o.g = g; o.y = y; o.ar = ar; o.rem = rem; o.busy = b;
        return o;
    endfunction

    out_t       exp_q[$];    // internal phase state for each upcoming cycle
    out_t       s_prev;
    out_t       s_now;
    out_t       exp_now;     // what the registered outputs must show now
    logic [3:0] m_pend;
    logic [3:0] m_clr;
    int         m_last;
    int         m_win;

    // Whole served phase laid out cycle by cycle: N seconds of TD cycles each,
    // remain counting N..1.
    task automatic plan_phase(input int w);
        logic [3:0] oh;
        oh = 4'(1 << w);
        for (int j = 0; j < GS * TD; j++) exp_q.push_back(mk(oh, 4'b0, 1'b0, enc(GS - j / TD), 1'b1));
        if (w < 2) begin
            for (int j = 0; j < YS * TD; j++) exp_q.push_back(mk(4'b0, oh, 1'b0, enc(YS - j / TD), 1'b1));
        end
        for (int j = 0; j < AS * TD; j++) exp_q.push_back(mk(4'b0, 4'b0, 1'b1, enc(AS - j / TD), 1'b1));
    endtask

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_pend  = 4'b0000;
            m_last  = 3;
            s_prev  = mk(4'b0, 4'b0, 1'b1, 8'd0, 1'b0);
            exp_now = s_prev;
        end else begin
            m_clr = 4'b0000;
            if (exp_q.size() == 0 && m_pend != 4'b0000) begin
                m_win = -1;
                for (int i = 1; i <= 4; i++) begin
                    if (m_win < 0 && m_pend[(m_last + i) % 4]) m_win = (m_last + i) % 4;
                end
                m_last = m_win;
                m_clr  = 4'(1 << m_win);
                plan_phase(m_win);
            end
            if (exp_q.size() != 0) s_now = exp_q.pop_front();
            else                   s_now = mk(4'b0, 4'b0, 1'b1, 8'd0, 1'b0);
            m_pend  = (m_pend & ~m_clr) | req;
            exp_now = s_prev;
            s_prev  = s_now;
        end
    end

    // ---------------- scoreboard compare ----------------
    out_t act_now;
    always @(negedge clk) begin
        if (chk_en) begin
            act_now = mk(grant, yellow, all_red, remain, busy);
            checks++;
            if (act_now !== exp_now) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual g=%b y=%b ar=%b rem=%h busy=%b expected g=%b y=%b ar=%b rem=%h busy=%b",
                         $time, grant, yellow, all_red, remain, busy,
                         exp_now.g, exp_now.y, exp_now.ar, exp_now.rem, exp_now.busy);
            end
            checks++;
            if ($countones({grant, yellow}) > 1) begin
                errors++;
                $display("FAIL grant_yellow_exclusive actual grant=%b yellow=%b required at most one bit", grant, yellow);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        req2  = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // req = v is sampled at the next posedge (edge n); returns after edge n.
    task automatic pulse(input logic [3:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = 4'b0000;
    endtask

    int         cnt_g[4];
    int         cnt_y[4];
    int         cnt_ar, cnt_busy, cnt_mg, first_idx, first_rem;
    logic [3:0] seq_q[$];

    task automatic window(input int n);
        logic [3:0] prev;
        prev = 4'b0;
        for (int b = 0; b < 4; b++) begin cnt_g[b] = 0; cnt_y[b] = 0; end
        cnt_ar = 0; cnt_busy = 0; cnt_mg = 0; first_idx = -1; first_rem = -1;
        seq_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if (grant[b])  cnt_g[b]++;
                if (yellow[b]) cnt_y[b]++;
            end
            if (all_red && busy) cnt_ar++;
            if (busy) cnt_busy++;
            if (exp_now.g != 4'b0) cnt_mg++;
            if (grant != 4'b0 && grant != prev) seq_q.push_back(grant);
            if (grant != 4'b0 && first_idx < 0) begin
                first_idx = i;
                first_rem = int'(remain);
            end
            prev = grant;
        end
    endtask

    logic [7:0] exp12[4];
    logic [3:0] exp_seq[5];

    initial begin
`ifdef PHASE_BCD_EN
        exp12 = '{8'h12, 8'h11, 8'h10, 8'h09};
`else
        exp12 = '{8'd12, 8'd11, 8'd10, 8'd9};
`endif
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        do_reset();
        chk_en = 1'b1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_all_red", int'(all_red), 1);
        chk("rst_remain", int'(remain), 0);
        chk("rst_busy", int'(busy), 0);

        // Single road1 request.
        pulse(4'b0001);
        window(40);
        chk("t1_latency_idx", first_idx, 1);
        chk("t1_first_remain", first_rem, 3);
        chk("t1_green_cycles", cnt_g[0], 12);
        chk("t1_model_green_cycles", cnt_mg, 12);
        chk("t1_yellow_cycles", cnt_y[0], 8);
        chk("t1_allred_cycles", cnt_ar, 4);
        chk("t1_busy_cycles", cnt_busy, 24);
        chk("t1_end_busy", int'(busy), 0);
        chk("t1_end_remain", int'(remain), 0);

        // Two roads together: road1 first, road2 straight after ALLRED.
        do_reset();
        pulse(4'b0011);
        window(60);
        chk("t2_seq_len", seq_q.size(), 2);
        if (seq_q.size() >= 2) begin
            chk("t2_seq0", int'(seq_q[0]), 1);
            chk("t2_seq1", int'(seq_q[1]), 2);
        end
        chk("t2_green_r1", cnt_g[0], 12);
        chk("t2_green_r2", cnt_g[1], 12);
        chk("t2_yellow_r2", cnt_y[1], 8);
        chk("t2_allred_cycles", cnt_ar, 8);
        chk("t2_busy_cycles", cnt_busy, 48);
        chk("t2_end_busy", int'(busy), 0);

        // Pedestrian: no yellow.
        do_reset();
        pulse(4'b0100);
        window(30);
        chk("t3_green_p1", cnt_g[2], 12);
        chk("t3_yellow_total", cnt_y[0] + cnt_y[1] + cnt_y[2] + cnt_y[3], 0);
        chk("t3_allred_cycles", cnt_ar, 4);
        chk("t3_end_busy", int'(busy), 0);

        // All requests held: full rotation and wrap back to road1.
        do_reset();
        @(negedge clk);
        req = 4'b1111;
        window(92);
        req = 4'b0000;
        chk("t4_seq_len_ge5", int'(seq_q.size() >= 5), 1);
        for (int k = 0; k < 5; k++) begin
            if (k < seq_q.size()) chk($sformatf("t4_seq%0d", k), int'(seq_q[k]), int'(exp_seq[k]));
        end

        // Reset in the middle of GREEN, with a request pending.
        do_reset();
        pulse(4'b0001);
        @(negedge clk);
        chk("t5_lat_n1", int'(grant), 0);
        @(negedge clk);
        chk("t5_lat_n2", int'(grant), 1);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_grant", int'(grant), 0);
        chk("t5_rst_all_red", int'(all_red), 1);
        chk("t5_rst_remain", int'(remain), 0);
        chk("t5_rst_busy", int'(busy), 0);
        reset = 1'b0;
        window(8);
        chk("t5_pend_cleared", cnt_busy, 0);
        pulse(4'b0010);
        @(negedge clk);
        chk("t5_req2_n1", int'(grant), 0);
        @(negedge clk);
        chk("t5_req2_n2", int'(grant), 2);
        window(30);
        chk("t5_end_busy", int'(busy), 0);

        // Two-digit remain on the GREEN_S=12 instance.
        do_reset();
        @(negedge clk);
        req2 = 4'b0001;
        @(negedge clk);
        req2 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t6_grant", int'(grant2), 1);
        chk("t6_remain0", int'(remain2), int'(exp12[0]));
        for (int k = 1; k < 4; k++) begin
            repeat (TD) @(negedge clk);
            chk($sformatf("t6_remain%0d", k), int'(remain2), int'(exp12[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_arbiter.md
PHASE_ARBITER -- requirements
Module: phase_arbiter

Interface
REQ-001 Parameter TICK_DIV, 50000000, clk cycles per one-second tick.
REQ-002 Parameter GREEN_S, 10, green phase length in seconds (1..99).
REQ-003 Parameter YELLOW_S, 2, yellow phase length in seconds (1..99), road phases only.
REQ-004 Parameter ALLRED_S, 1, all-red clearance length in seconds (1..99).
REQ-005 Ports SHALL be exactly as follows. One clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  4  level requests: [0] road1, [1] road2, [2] ped1, [3] ped2.
- grant  out  4  one-hot green; zero when no green phase is active.
- yellow  out  4  one-hot yellow; bits [3:2] are always 0.
- all_red  out  1  high in IDLE and ALLRED.
- remain  out  8  seconds left in the current phase; 0 in IDLE.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-006 Pending latch: pend_next = (pend & ~clr_on_grant) | req; a req bit high in its own grant cycle re-sets the bit (set wins).
REQ-007 States are IDLE, GREEN, YELLOW, ALLRED; all outputs are registered.
REQ-008 Arbitration is round-robin over pend, starting at (last_granted+1) mod 4; it is evaluated only in IDLE and on ALLRED expiry.
REQ-009 Transitions:
- IDLE -> GREEN when pend is nonzero.
- GREEN -> YELLOW on expiry for road bits; GREEN -> ALLRED on expiry for ped bits.
- YELLOW -> ALLRED on expiry.
- ALLRED -> GREEN of the next winner, or -> IDLE if pend is zero.
REQ-010 Latency: req high and sampled at edge n gives grant high after edge n+2 (from IDLE).
REQ-011 The sub-second counter SHALL restart on every state entry; tick pulses when the count equals TICK_DIV-1.
REQ-012 Phase duration:
- remain loads GREEN_S, YELLOW_S or ALLRED_S on entry and decrements on each tick.
- The state exits on the tick where remain==1.
- Each phase therefore lasts exactly N*TICK_DIV cycles, and remain shows N..1.
REQ-013 grant and yellow SHALL never be nonzero simultaneously; at most one bit of the pair (grant, yellow) is high.
REQ-014 Requests arriving during a phase SHALL NOT preempt it; they are served in round-robin order after ALLRED.
REQ-015 last_granted SHALL update only on entry to GREEN.

Reset
REQ-016 When reset is high at an edge, the block SHALL apply the following on that edge:
- state=IDLE, grant=0, yellow=0, all_red=1, remain=0, busy=0.
- pend=0, last_granted=3, so req[0] has first priority.
- Sub-second counter=0.
REQ-017 A reset in any state, including mid-phase, SHALL take effect on the next edge, with no yellow or clearance completion.

Configuration
REQ-018 With PHASE_BCD_EN defined, remain SHALL be two packed BCD digits (tens in [7:4]); the decrement is BCD, e.g. 8'h10 -> 8'h09.
REQ-019 Without PHASE_BCD_EN, remain SHALL be plain binary.

Structure
REQ-020 Package phase_pkg SHALL hold:
- the state encoding;
- requester index constants (ROAD1=0, ROAD2=1, PED1=2, PED2=3);
- default timing constants.
REQ-021 Sub-module sec_tick SHALL hold the TICK_DIV prescaler, with a restart input and a one-cycle tick output.

Verification (TICK_DIV=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1)
REQ-022 Pulse req=0001 for one cycle after reset -> grant=0001 for 12 cycles (remain 3,2,1), then yellow=0001 for 8 cycles, then all_red for 4 cycles, then IDLE with busy=0 and remain=0.
REQ-023 Pulse req=0011 for one cycle -> grant=0001 phase first, then directly after ALLRED a grant=0010 phase, then IDLE.
REQ-024 Pulse req=0100 -> grant=0100 for 12 cycles, yellow stays 0, all_red for 4 cycles.
REQ-025 Hold req=1111 -> grant sequence 0001, 0010, 0100, 1000, 0001, with no cycle where grant and yellow are both nonzero.
REQ-026 Assert reset at cycle 5 of a GREEN -> on the next edge grant=0, all_red=1, remain=0, pend=0; a following req=0010 is granted 2 edges after it is sampled.
REQ-027 Set GREEN_S=12 with PHASE_BCD_EN -> remain 8'h12, 8'h11, 8'h10, 8'h09, ...; set GREEN_S=12 without the macro -> remain 12, 11, 10, 9, ....
